// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM loaded over a valid/ready port, combinational fetch for the core.
// Fetch is zero-latency; load_ready, load_done, core_reset_n and word_count are registered (1 cycle).
// Loader is backpressured by load_ready (low outside LOAD); optional IMEM_FETCH_CNT_EN adds fetch/error counters.
module imem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          RELEASE_DLY = 4,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic                     SystemClock,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [31:0]              load_data,
    input  logic                     load_last,
    output logic                     load_done,
    input  logic [31:0]              PC,
    output logic [31:0]              mem_ins,
    output logic                     core_reset_n,
    output logic                     fetch_err,
    output logic [$clog2(DEPTH):0]   word_count
`ifdef IMEM_FETCH_CNT_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [15:0]              err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(RELEASE_DLY + 1);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RELEASE_DLY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wc_q, wc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          load_ready_q;
    logic          load_done_q, load_done_d;
    logic          core_rst_n_q;
    logic          wr_en;
    logic          accept;
    logic [AW:0]   wc_inc;

    logic [31:0]   mem [DEPTH];

    assign accept = load_valid && load_ready_q;
    assign wc_inc = wc_q + 1'b1;

    // Next-state logic: load sequencing, image close, and release delay countdown.
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        hold_d      = hold_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                end
            end
            LOAD: begin
                // A restart wins over a word accepted in the same cycle.
                if (load_start) begin
                    wc_d = '0;
                end else if (accept) begin
                    wr_en = 1'b1;
                    wc_d  = wc_inc;
                    if (load_last || (wc_inc == DEPTH_W)) begin
                        state_d     = HOLD;
                        hold_d      = '0;
                        load_done_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (load_start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                end else if (hold_q == HOLD_MAX) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered outputs, all derived from the next state.
    always_ff @(posedge SystemClock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wc_q         <= '0;
            hold_q       <= '0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            hold_q       <= hold_d;
            load_ready_q <= (state_d == LOAD);
            load_done_q  <= load_done_d;
            core_rst_n_q <= (state_d == RUN);
        end
    end

    // RAM write port; contents survive reset because word_count masks stale words.
    always_ff @(posedge SystemClock) begin
        if (wr_en) begin
            mem[wc_q[AW-1:0]] <= load_data;
        end
    end

    // Combinational fetch: same-cycle write to the fetched index returns the old word.
    logic [AW-1:0] idx;
    logic          aligned;
    logic          in_range;
    logic          hit;

    assign idx       = PC[AW+1:2];
    assign aligned   = (PC[1:0] == 2'b00);
    assign in_range  = (PC[31:AW+2] == '0);
    assign hit       = aligned && in_range && ({1'b0, idx} < wc_q);
    assign mem_ins   = hit ? mem[idx] : NOP_WORD;
    assign fetch_err = !aligned || !in_range;

    assign load_ready   = load_ready_q;
    assign load_done    = load_done_q;
    assign core_reset_n = core_rst_n_q;
    assign word_count   = wc_q;

`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] pc_q;
    logic [31:0] fetch_count_q;
    logic [15:0] err_count_q;

    // Fetch activity counters: PC changes and faulting fetches while the core runs.
    always_ff @(posedge SystemClock or negedge reset) begin
        if (!reset) begin
            pc_q          <= '0;
            fetch_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            pc_q <= PC;
            if ((state_d == LOAD) && (state_q != LOAD)) begin
                fetch_count_q <= '0;
            end else if ((state_q == RUN) && (PC != pc_q)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if ((state_q == RUN) && fetch_err && (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: load, release timing, fetch checks, auto-close, restart, abort.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
// Every DUT wait is bounded and a timeout is reported as a failed comparison.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        SystemClock = 1'b0;
    logic        reset       = 1'b0;
    logic        load_start  = 1'b0;
    logic        load_valid  = 1'b0;
    logic        load_ready;
    logic [31:0] load_data   = '0;
    logic        load_last   = 1'b0;
    logic        load_done;
    logic [31:0] PC          = '0;
    logic [31:0] mem_ins;
    logic        core_reset_n;
    logic        fetch_err;
    logic [8:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;

    imem_responder dut (
        .SystemClock (SystemClock),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_done   (load_done),
        .PC          (PC),
        .mem_ins     (mem_ins),
        .core_reset_n(core_reset_n),
        .fetch_err   (fetch_err),
        .word_count  (word_count)
    );

    always #5 SystemClock = ~SystemClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge SystemClock);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present one word after 'gap' idle cycles and hold it until handshaked.
    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        int c;
        repeat (gap) tick();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        c = 0;
        while (!load_ready && c < 20) begin
            tick();
            c++;
        end
        check("ready_wait", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run();
        int c;
        c = 0;
        while (!core_reset_n && c < 50) begin
            tick();
            c++;
        end
        check("run_wait", {31'd0, core_reset_n}, 32'd1);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic err);
        PC = pc;
        #1;
        check({tag, "_ins"}, mem_ins, ins);
        check({tag, "_err"}, {31'd0, fetch_err}, {31'd0, err});
    endtask

    logic [31:0] prog [3];
    int cyc;

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00a00113;
        prog[2] = 32'h002081b3;

        // Reset values.
        #12;
        check("rst_ready", {31'd0, load_ready}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_crn", {31'd0, core_reset_n}, 32'd0);
        check("rst_wc", {23'd0, word_count}, 32'd0);
        fetch("rst_pc0", 32'h0, NOP, 1'b0);
        @(posedge SystemClock);
        #1;
        reset = 1'b1;
        tick();
        check("idle_ready", {31'd0, load_ready}, 32'd0);

        // Three-word program, release timing.
        pulse_start();
        check("load_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 3; i++) send_word(prog[i], (i == 2), 0);
        check("p1_done", {31'd0, load_done}, 32'd1);
        check("p1_wc", {23'd0, word_count}, 32'd3);
        tick();
        cyc = 1;
        check("p1_done_off", {31'd0, load_done}, 32'd0);
        check("p1_ready_off", {31'd0, load_ready}, 32'd0);
        check("p1_crn_hold", {31'd0, core_reset_n}, 32'd0);
        while (!core_reset_n && cyc < 20) begin
            tick();
            cyc++;
        end
        check("p1_release_dly", cyc, 32'd5);

        // Fetches in RUN.
        fetch("f0", 32'h0, 32'h00500093, 1'b0);
        fetch("f4", 32'h4, 32'h00a00113, 1'b0);
        fetch("f8", 32'h8, 32'h002081b3, 1'b0);
        fetch("f12", 32'hC, NOP, 1'b0);
        fetch("mis", 32'h2, NOP, 1'b1);
        fetch("oor", 32'h400, NOP, 1'b1);
        fetch("top", 32'h3FC, NOP, 1'b0);
        fetch("hi", 32'h8000_0000, NOP, 1'b1);
        PC = '0;

        // Full image without load_last: auto-close at DEPTH.
        pulse_start();
        check("full_crn_low", {31'd0, core_reset_n}, 32'd0);
        for (int i = 0; i < 256; i++) send_word(32'hA000_0000 + i, 1'b0, 0);
        check("full_done", {31'd0, load_done}, 32'd1);
        check("full_wc", {23'd0, word_count}, 32'd256);
        tick();
        check("full_ready_off", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        load_valid = 1'b0;
        check("full_wc_after", {23'd0, word_count}, 32'd256);
        fetch("full_w0", 32'h0, 32'hA000_0000, 1'b0);
        fetch("full_w128", 32'h200, 32'hA000_0080, 1'b0);
        fetch("full_w255", 32'h3FC, 32'hA000_00FF, 1'b0);
        wait_run();

        // Gapped load with a mid-load restart; the restart-cycle word is dropped.
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(32'h11 * (i + 1), 1'b0, int'($urandom_range(0, 2)));
        check("rs_wc_pre", {23'd0, word_count}, 32'd3);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h0000_0BAD;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("rs_wc_zero", {23'd0, word_count}, 32'd0);
        for (int i = 0; i < 4; i++) send_word(32'h1000 + i, (i == 3), int'($urandom_range(0, 3)));
        check("rs_wc", {23'd0, word_count}, 32'd4);
        for (int i = 0; i < 4; i++) fetch("rs_w", 32'(i * 4), 32'h1000 + i, 1'b0);
        fetch("rs_masked", 32'h10, NOP, 1'b0);
        wait_run();

        // Reload from RUN, then abort with reset mid-load.
        pulse_start();
        check("ab_crn_low", {31'd0, core_reset_n}, 32'd0);
        check("ab_wc_zero", {23'd0, word_count}, 32'd0);
        send_word(32'h5555_5555, 1'b0, 0);
        check("ab_wc_one", {23'd0, word_count}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ab_crn", {31'd0, core_reset_n}, 32'd0);
        check("ab_wc", {23'd0, word_count}, 32'd0);
        check("ab_ready", {31'd0, load_ready}, 32'd0);
        fetch("ab_f0", 32'h0, NOP, 1'b0);
        fetch("ab_f4", 32'h4, NOP, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("ab_idle_crn", {31'd0, core_reset_n}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch side of RISC_V_pipeline. The core drives PC; this block returns mem_ins.
- Owns a word-addressed instruction RAM filled via a valid/ready load port, and holds the core in reset until a program image is loaded.
- Sits between the load source (bench or boot loader) and the core, replacing bench-driven mem_ins.

Parameters:
- DEPTH, 256, number of 32-bit instruction words (power of 2, >= 4).
- RELEASE_DLY, 4, cycles core_reset_n stays low after the last load word (>= 1).
- NOP_WORD, 32'h00000013, word returned for any invalid fetch (addi x0,x0,0).

Ports:
- SystemClock  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low block reset.
- load_start  input  1  one-cycle pulse requesting a new program load.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block accepts a word this cycle.
- load_data  input  32  instruction word; the Nth accepted word goes to index N-1.
- load_last  input  1  qualifies the final word of the image.
- load_done  output  1  one-cycle pulse when the image is closed.
- PC  input  32  byte address from the core.
- mem_ins  output  32  instruction for PC.
- core_reset_n  output  1  active-low reset to the core.
- fetch_err  output  1  the current PC is misaligned or out of range.
- word_count  output  log2(DEPTH)+1  number of valid words in the current image.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, load_ready=0, load_done=0, core_reset_n=0, word_count=0, hold counter=0. RAM contents are not cleared; word_count masks them.
- FSM states: IDLE, LOAD, HOLD, RUN.
- IDLE: load_ready=0, core_reset_n=0. load_start -> LOAD and word_count=0.
- LOAD: load_ready=1, core_reset_n=0.
  - A word is accepted when load_valid && load_ready: write RAM[word_count] and increment word_count.
  - The image closes on an accepted word with load_last=1, or on the accepted word that makes word_count==DEPTH. Closing moves to HOLD, pulses load_done for exactly 1 cycle, and deasserts load_ready on the next cycle.
  - Words presented with load_valid while load_ready=0 are ignored.
  - load_start during LOAD restarts the load: word_count=0, stay in LOAD. Any word accepted in that same cycle is discarded.
- HOLD: load_ready=0, core_reset_n=0. Counts RELEASE_DLY cycles, then moves to RUN. core_reset_n is registered and goes high on the first RUN cycle.
- RUN: core_reset_n=1. load_start -> LOAD with word_count=0, and core_reset_n low in the next cycle (registered).
- load_start in HOLD behaves as in RUN.
- Fetch path is combinational, zero-latency, and valid in every state:
  - idx = PC[log2(DEPTH)+1:2].
  - mem_ins = RAM[idx] when PC[1:0]==0, PC < 4*DEPTH, and idx < word_count. Otherwise mem_ins = NOP_WORD.
  - fetch_err = 1 on misalignment or PC >= 4*DEPTH. An in-range index at or beyond word_count is not an error: it returns NOP with fetch_err=0.
- Same-cycle write/fetch to the same index (only possible during LOAD, with the core held in reset): the old word is returned, and the new word is visible from the next cycle.
- Asserting reset mid-load aborts the load: word_count=0 and the core stays in reset.
- Registered outputs: load_ready, load_done, core_reset_n, word_count. mem_ins and fetch_err are combinational from PC and the RAM.

Optional Feature:
- Macro: IMEM_FETCH_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0], reset to 0 and cleared on entering LOAD.
  - In RUN, fetch_count increments on every cycle where PC differs from the previous cycle's registered PC.
  - Adds output err_count [15:0], which increments on every RUN cycle with fetch_err=1 and saturates at 16'hFFFF.
- Undefined: neither port nor its registers exist. All other behaviour is identical.

Test Plan:
- Reset, then load_start and 3 words {32'h00500093, 32'h00a00113, 32'h002081b3} with load_last on the 3rd -> load_done pulses 1 cycle, word_count=3, core_reset_n rises exactly RELEASE_DLY+1 cycles after the last accept.
- RUN, PC=0/4/8/12 -> mem_ins = 00500093/00a00113/002081b3/00000013, fetch_err=0 throughout.
- PC=32'h2 -> NOP, fetch_err=1. PC=4*DEPTH (32'h400) -> NOP, fetch_err=1.
- Load DEPTH words with no load_last -> closes automatically on word DEPTH, word_count=256, load_ready low afterwards, and an extra load_valid word is not written.
- load_valid toggled randomly during LOAD -> only handshaked words are stored, in order. A load_start mid-load restarts at index 0.
- In RUN, load_start then reset low mid-load -> core_reset_n=0 immediately, word_count=0, all fetches return NOP.
